// File: rtl/ddiffn_if.sv
// ddiffn_if -- sample/control and result bundle for the ddiffn difference unit.
//   master: drives clr, in_valid, in_mag, in_sign, sel; observes all results.
//   slave : the ddiffn core; drives dd_mag, dd_sign, out_mag, out_sign,
//           out_valid, out_primed, ovf.
// Parameters must match the ddiffn instance attached to the slave side.
interface ddiffn_if #(
  parameter int W     = 16,
  parameter int ORDER = 3,
  parameter int SW    = $clog2(ORDER + 1)
) ();
  logic                 clr;
  logic                 in_valid;
  logic [W-1:0]         in_mag;
  logic                 in_sign;
  logic [SW-1:0]        sel;
  logic [ORDER*W-1:0]   dd_mag;
  logic [ORDER-1:0]     dd_sign;
  logic [W-1:0]         out_mag;
  logic                 out_sign;
  logic                 out_valid;
  logic                 out_primed;
  logic                 ovf;

  modport master (
    output clr, in_valid, in_mag, in_sign, sel,
    input  dd_mag, dd_sign, out_mag, out_sign, out_valid, out_primed, ovf
  );

  modport slave (
    input  clr, in_valid, in_mag, in_sign, sel,
    output dd_mag, dd_sign, out_mag, out_sign, out_valid, out_primed, ovf
  );
endinterface

// File: rtl/ddiffn.sv
// ddiffn -- N-th order chained backward-difference unit on sign-magnitude
// samples. Stage k holds the k-th backward difference of the input stream.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ddiffn_if.slave: clr, in_valid, in_mag, in_sign, sel in;
//          dd_mag/dd_sign (all stages), out_* (selected stage), ovf out.
// Build option: DDIFFN_SAT_EN -- when defined, an overflowing magnitude
// clamps to 2^W-1; otherwise it wraps to the low W bits. Sign kept either way.
module ddiffn #(
  parameter int W     = 16,
  parameter int ORDER = 3,
  parameter int SW    = $clog2(ORDER + 1)
) (
  input logic      clk,
  input logic      rst_n,
  ddiffn_if.slave  bus
);

  // Stage state.
  logic [W-1:0]   d_mag_q  [ORDER];
  logic [W-1:0]   p_mag_q  [ORDER];
  logic [ORDER-1:0] d_sign_q;
  logic [ORDER-1:0] p_sign_q;
  logic [ORDER-1:0] v_q;
  logic [ORDER-1:0] pr_q;
  logic [ORDER-1:0] seen_q;   // stage has accepted a primed input already
  logic [ORDER-1:0] o_q;

  // Per-stage input selection and update value.
  logic [W-1:0]   src_mag_s  [ORDER];
  logic           src_sign_s [ORDER];
  logic           src_stb_s  [ORDER];
  logic           src_pr_s   [ORDER];
  logic [W+1:0]   upd_d      [ORDER];   // {ovf, sign, mag}

  logic [SW-1:0]  sel_idx_s;

  // Exact sign-magnitude subtraction a - b; returns {ovf, sign, mag}.
  // A zero result always carries sign 0, so -0 operands never leak through.
  function automatic logic [W+1:0] sm_sub(
    input logic [W-1:0] a_mag, input logic a_sign,
    input logic [W-1:0] b_mag, input logic b_sign
  );
    logic signed [W+1:0] a_v;
    logic signed [W+1:0] b_v;
    logic signed [W+1:0] diff_v;
    logic        [W+1:0] abs_v;
    logic        [W-1:0] mag_v;
    a_v    = a_sign ? -$signed({2'b00, a_mag}) : $signed({2'b00, a_mag});
    b_v    = b_sign ? -$signed({2'b00, b_mag}) : $signed({2'b00, b_mag});
    diff_v = a_v - b_v;
    abs_v  = diff_v[W+1] ? -diff_v : diff_v;
`ifdef DDIFFN_SAT_EN
    if (abs_v[W]) begin
      mag_v = {W{1'b1}};
    end else begin
      mag_v = abs_v[W-1:0];
    end
`else
    mag_v = abs_v[W-1:0];
`endif
    return {abs_v[W], diff_v[W+1], mag_v};
  endfunction

  for (genvar k = 0; k < ORDER; k++) begin : g_stage
    if (k == 0) begin : g_head
      // First stage sees the raw sample, which is always primed.
      assign src_mag_s[k]  = bus.in_mag;
      assign src_sign_s[k] = bus.in_sign;
      assign src_stb_s[k]  = bus.in_valid;
      assign src_pr_s[k]   = 1'b1;
    end else begin : g_tail
      assign src_mag_s[k]  = d_mag_q[k-1];
      assign src_sign_s[k] = d_sign_q[k-1];
      assign src_stb_s[k]  = v_q[k-1];
      assign src_pr_s[k]   = pr_q[k-1];
    end
    assign upd_d[k] = sm_sub(src_mag_s[k], src_sign_s[k], p_mag_q[k], p_sign_q[k]);
    assign bus.dd_mag[k*W +: W] = d_mag_q[k];
  end

  assign bus.dd_sign = d_sign_q;

  // Stage registers: update on strobe, clear on reset or clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        d_mag_q[k] <= {W{1'b0}};
        p_mag_q[k] <= {W{1'b0}};
      end
      d_sign_q <= {ORDER{1'b0}};
      p_sign_q <= {ORDER{1'b0}};
      v_q      <= {ORDER{1'b0}};
      pr_q     <= {ORDER{1'b0}};
      seen_q   <= {ORDER{1'b0}};
      o_q      <= {ORDER{1'b0}};
    end else if (bus.clr) begin
      // A sample arriving with clr is dropped.
      for (int k = 0; k < ORDER; k++) begin
        d_mag_q[k] <= {W{1'b0}};
        p_mag_q[k] <= {W{1'b0}};
      end
      d_sign_q <= {ORDER{1'b0}};
      p_sign_q <= {ORDER{1'b0}};
      v_q      <= {ORDER{1'b0}};
      pr_q     <= {ORDER{1'b0}};
      seen_q   <= {ORDER{1'b0}};
      o_q      <= {ORDER{1'b0}};
    end else begin
      for (int k = 0; k < ORDER; k++) begin
        if (src_stb_s[k]) begin
          d_mag_q[k]  <= upd_d[k][W-1:0];
          d_sign_q[k] <= upd_d[k][W];
          o_q[k]      <= upd_d[k][W+1];
          p_mag_q[k]  <= src_mag_s[k];
          p_sign_q[k] <= src_sign_s[k];
          v_q[k]      <= 1'b1;
          // Primed once a primed input arrives after an earlier primed one.
          pr_q[k]     <= src_pr_s[k] & seen_q[k];
          seen_q[k]   <= seen_q[k] | src_pr_s[k];
        end else begin
          v_q[k]      <= 1'b0;
        end
      end
    end
  end

  // Order select: 0 maps to stage 1, anything above ORDER maps to stage ORDER.
  always_comb begin
    sel_idx_s = {SW{1'b0}};
    if (bus.sel == {SW{1'b0}}) begin
      sel_idx_s = {SW{1'b0}};
    end else if (bus.sel > SW'(ORDER)) begin
      sel_idx_s = SW'(ORDER - 1);
    end else begin
      sel_idx_s = bus.sel - SW'(1);
    end
  end

  assign bus.out_mag    = d_mag_q[sel_idx_s];
  assign bus.out_sign   = d_sign_q[sel_idx_s];
  assign bus.out_valid  = v_q[sel_idx_s];
  assign bus.out_primed = pr_q[sel_idx_s];
  assign bus.ovf        = o_q[sel_idx_s];

endmodule

// File: tb/tb_ddiffn.sv
// tb_ddiffn -- directed self-checking bench for ddiffn (W=16, ORDER=3).
module tb_ddiffn;
  localparam int W     = 16;
  localparam int ORDER = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ddiffn_if #(.W(W), .ORDER(ORDER)) bus ();

  ddiffn #(.W(W), .ORDER(ORDER)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] mag, input logic sgn);
    bus.in_valid = 1'b1;
    bus.in_mag   = mag;
    bus.in_sign  = sgn;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  int exp1 [5] = '{0, 3, 3, 3, 3};
  int exp2 [5] = '{0, 3, 0, 0, 0};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n        = 1'b0;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_mag   = 16'd0;
    bus.in_sign  = 1'b0;
    bus.sel      = 2'd2;

    // Reset held with random traffic.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mag   = 16'($urandom);
      bus.in_sign  = 1'($urandom);
      tick();
    end
    check_eq("rst_dd_mag", 64'(bus.dd_mag), 64'd0);
    check_eq("rst_dd_sign", 64'(bus.dd_sign), 64'd0);
    check_eq("rst_out", 64'({bus.out_mag, bus.out_sign, bus.out_valid, bus.out_primed, bus.ovf}), 64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick(); tick(); tick();
    check_eq("idle_dd_mag", 64'(bus.dd_mag), 64'd0);
    check_eq("idle_out", 64'({bus.out_mag, bus.out_sign, bus.out_valid, bus.out_primed, bus.ovf}), 64'd0);

    // Back-to-back ramp 0,3,6,9,12 with sel=2.
    bus.sel = 2'd2;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        bus.in_valid = 1'b1;
        bus.in_mag   = 16'(3 * i);
        bus.in_sign  = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (i < 5) check_eq($sformatf("ramp_dd1_%0d", i), 64'(bus.dd_mag[15:0]), 64'(exp1[i]));
      if (i == 0) check_eq("ramp_ov_first", 64'(bus.out_valid), 64'd0);
      if (i >= 1 && i <= 5) begin
        check_eq($sformatf("ramp_dd2_%0d", i - 1), 64'(bus.out_mag), 64'(exp2[i-1]));
        check_eq($sformatf("ramp_ov_%0d", i - 1), 64'(bus.out_valid), 64'd1);
        check_eq($sformatf("ramp_pr_%0d", i - 1), 64'(bus.out_primed), 64'((i - 1) >= 2));
      end
      if (i == 4) check_eq("ramp_dd3_neg", 64'({bus.dd_sign[2], bus.dd_mag[47:32]}), 64'h1_0003);
      if (i == 6) check_eq("ramp_ov_end", 64'(bus.out_valid), 64'd0);
    end
    bus.sel = 2'd0;
    #1;
    check_eq("sel0_mag", 64'(bus.out_mag), 64'd3);
    check_eq("sel0_pr", 64'(bus.out_primed), 64'd1);
    bus.sel = 2'd3;
    #1;
    check_eq("sel3_mag", 64'({bus.out_sign, bus.out_mag}), 64'd0);
    check_eq("sel3_pr", 64'(bus.out_primed), 64'd1);

    // Sign handling: +10 then +4; +0 then -0.
    bus.sel = 2'd1;
    do_clr();
    check_eq("clr_dd_mag", 64'(bus.dd_mag), 64'd0);
    send(16'd10, 1'b0);
    check_eq("s10", 64'({bus.out_sign, bus.out_mag}), 64'd10);
    send(16'd4, 1'b0);
    check_eq("s4", 64'({bus.out_sign, bus.out_mag}), 64'h1_0006);
    do_clr();
    send(16'd0, 1'b0);
    check_eq("pz", 64'({bus.out_sign, bus.out_mag}), 64'd0);
    send(16'd0, 1'b1);
    check_eq("nz", 64'({bus.out_sign, bus.out_mag}), 64'd0);

    // Overflow: +65535 then -65535.
    do_clr();
    send(16'd65535, 1'b0);
    check_eq("ovf_pre", 64'({bus.ovf, bus.out_sign, bus.out_mag}), 64'd65535);
    send(16'd65535, 1'b1);
`ifdef DDIFFN_SAT_EN
    check_eq("ovf_hit", 64'({bus.ovf, bus.out_sign, bus.out_mag}), 64'h3_FFFF);
`else
    check_eq("ovf_hit", 64'({bus.ovf, bus.out_sign, bus.out_mag}), 64'h3_FFFE);
`endif
    tick();
    check_eq("ovf_hold", 64'(bus.ovf), 64'd1);
    send(16'd65535, 1'b1);
    check_eq("ovf_clear", 64'({bus.ovf, bus.out_sign, bus.out_mag}), 64'd0);

    // clr with coincident sample discards the sample.
    bus.clr = 1'b1;
    send(16'd7, 1'b0);
    bus.clr = 1'b0;
    check_eq("clr_drop", 64'({bus.out_valid, bus.dd_mag}), 64'd0);
    send(16'd5, 1'b0);
    check_eq("clr_first", 64'(bus.out_mag), 64'd5);

    // Ramp with gaps of 1..3 idle cycles, sel=2.
    do_clr();
    bus.sel = 2'd2;
    for (int i = 0; i < 5; i++) begin
      send(16'(3 * i), 1'b0);
      check_eq($sformatf("gap_dd1_%0d", i), 64'(bus.dd_mag[15:0]), 64'(exp1[i]));
      for (int g = 0; g < 1 + (i % 3); g++) begin
        tick();
        check_eq($sformatf("gap_hold1_%0d_%0d", i, g), 64'(bus.dd_mag[15:0]), 64'(exp1[i]));
        check_eq($sformatf("gap_dd2_%0d_%0d", i, g), 64'(bus.out_mag), 64'(exp2[i]));
        check_eq($sformatf("gap_ov_%0d_%0d", i, g), 64'(bus.out_valid), 64'(g == 0));
        if (g == 0) check_eq($sformatf("gap_pr_%0d", i), 64'(bus.out_primed), 64'(i >= 2));
      end
    end

    // clr mid-ramp: everything drops, priming restarts.
    do_clr();
    send(16'd3, 1'b0);
    send(16'd6, 1'b0);
    do_clr();
    check_eq("midclr_all", 64'({bus.dd_mag, bus.dd_sign}), 64'd0);
    bus.sel = 2'd1;
    send(16'd9, 1'b0);
    check_eq("midclr_dd1", 64'({bus.out_primed, bus.out_mag}), 64'd9);
    send(16'd12, 1'b0);
    check_eq("midclr_pr", 64'({bus.out_primed, bus.out_mag}), 64'h1_0003);

    // Asynchronous reset pulse between edges.
    send(16'd15, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_dd", 64'({bus.dd_mag, bus.dd_sign}), 64'd0);
    check_eq("arst_out", 64'({bus.out_valid, bus.out_mag, bus.ovf}), 64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    send(16'd7, 1'b1);
    check_eq("arst_first", 64'({bus.out_sign, bus.out_mag}), 64'h1_0007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
